// File: rtl/nand_pkg.sv
// Shared constants and the NAND primitive for the nand_gate block.
// Operands are handled at the maximum width; callers slice the result.
package nand_pkg;

    localparam int NAND_WIDTH_DEF = 1;
    localparam int NAND_CNT_W_DEF = 16;
    localparam int NAND_MAX_W     = 64;

    // Bitwise NAND at the widest legal operand width
    function automatic logic [NAND_MAX_W-1:0] nand_f(
        input logic [NAND_MAX_W-1:0] a,
        input logic [NAND_MAX_W-1:0] b
    );
        return ~(a & b);
    endfunction

endpackage

// File: rtl/nand_gate.sv
// Bitwise NAND: combinational result plus a one-cycle registered copy.
// Optional saturating operation counter enabled by NAND_OP_COUNT_EN.
module nand_gate
    import nand_pkg::*;
#(
    parameter int WIDTH = NAND_WIDTH_DEF,
    parameter int CNT_W = NAND_CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y,
    input  logic             in_valid,
    output logic [WIDTH-1:0] y_q,
    output logic             out_valid,
    output logic             all_low
`ifdef NAND_OP_COUNT_EN
    ,
    output logic [CNT_W-1:0] op_count
`endif
);

    // Reject illegal configurations at elaboration
    if (WIDTH < 1 || WIDTH > NAND_MAX_W || CNT_W < 1) begin : g_param_err
        $error("nand_gate: WIDTH must be 1..64 and CNT_W >= 1");
    end

    logic [NAND_MAX_W-1:0] a_ext;
    logic [NAND_MAX_W-1:0] b_ext;
    logic [NAND_MAX_W-1:0] y_full;

    logic [WIDTH-1:0] res_d;
    logic [WIDTH-1:0] res_q;
    logic             vld_d;
    logic             vld_q;

    // Pad unused operand bits with ones so the padded result bits are zero
    always_comb begin
        a_ext = '1;
        b_ext = '1;
        a_ext[WIDTH-1:0] = a;
        b_ext[WIDTH-1:0] = b;
    end

    assign y_full  = nand_f(a_ext, b_ext);
    assign y       = y_full[WIDTH-1:0];
    assign all_low = ~|y_full;

    // Capture a new result only when the operands are qualified
    always_comb begin
        vld_d = in_valid;
        res_d = res_q;
        if (in_valid) begin
            res_d = y_full[WIDTH-1:0];
        end
    end

    // Result register; reset value is the NAND of all-zero operands
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_q <= '1;
            vld_q <= 1'b0;
        end else begin
            res_q <= res_d;
            vld_q <= vld_d;
        end
    end

    assign y_q       = res_q;
    assign out_valid = vld_q;

`ifdef NAND_OP_COUNT_EN
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] cnt_q;

    // Count accepted operations, holding at the maximum value
    always_comb begin
        cnt_d = cnt_q;
        if (in_valid && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Operation counter register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign op_count = cnt_q;
`endif

endmodule

// File: tb/tb_nand_gate.sv
// Self-checking bench for nand_gate (WIDTH=8/CNT_W=2 and WIDTH=1).
// Counter checks are active when NAND_OP_COUNT_EN is defined.
module tb_nand_gate;

    logic       clk;
    logic       rst;

    logic [7:0] a8;
    logic [7:0] b8;
    logic       v8;
    logic [7:0] y8;
    logic [7:0] yq8;
    logic       ov8;
    logic       al8;

    logic       a1;
    logic       b1;
    logic       v1;
    logic       y1;
    logic       yq1;
    logic       ov1;
    logic       al1;

`ifdef NAND_OP_COUNT_EN
    logic [1:0]  cnt8;
    logic [15:0] cnt1;
`endif

    int checks;
    int errors;

    // Reference state: last accepted result, valid flag, accepted total
    logic [7:0]  exp_yq;
    logic        exp_ov;
    int unsigned n_acc;

    nand_gate #(.WIDTH(8), .CNT_W(2)) u_dut8 (
        .clk       (clk),
        .rst       (rst),
        .a         (a8),
        .b         (b8),
        .y         (y8),
        .in_valid  (v8),
        .y_q       (yq8),
        .out_valid (ov8),
        .all_low   (al8)
`ifdef NAND_OP_COUNT_EN
        ,
        .op_count  (cnt8)
`endif
    );

    nand_gate #(.WIDTH(1)) u_dut1 (
        .clk       (clk),
        .rst       (rst),
        .a         (a1),
        .b         (b1),
        .y         (y1),
        .in_valid  (v1),
        .y_q       (yq1),
        .out_valid (ov1),
        .all_low   (al1)
`ifdef NAND_OP_COUNT_EN
        ,
        .op_count  (cnt1)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t",
                     tag, got, exp, $time);
        end
    endtask

    task automatic check_regs();
        check("y_q8", 64'(yq8), 64'(exp_yq));
        check("out_valid8", 64'(ov8), 64'(exp_ov));
`ifdef NAND_OP_COUNT_EN
        check("op_count8", 64'(cnt8), 64'((n_acc > 3) ? 3 : n_acc));
`endif
    endtask

    task automatic model_reset();
        exp_yq = 8'hFF;
        exp_ov = 1'b0;
        n_acc  = 0;
    endtask

    // Called at posedge+1; drives one cycle and checks both stages
    task automatic step8(input logic [7:0] na, input logic [7:0] nb,
                         input logic nv);
        logic [7:0] ey;
        ey = ~(na & nb);
        a8 = na;
        b8 = nb;
        v8 = nv;
        #1;
        check("y8", 64'(y8), 64'(ey));
        check("all_low8", 64'(al8), 64'(ey == 8'h00));
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            exp_ov = nv;
            if (nv) begin
                exp_yq = ey;
                n_acc++;
            end
        end
        #1;
        check_regs();
    endtask

    initial begin
        logic [1:0] tbl_ab [4];
        logic       tbl_y  [4];
        checks = 0;
        errors = 0;
        rst = 1'b1;
        a8 = 8'h00; b8 = 8'h00; v8 = 1'b0;
        a1 = 1'b0;  b1 = 1'b0;  v1 = 1'b0;
        model_reset();
        #2;
        check_regs();
        check("y_q1_rst", 64'(yq1), 64'd1);
        check("out_valid1_rst", 64'(ov1), 64'd0);
        check("y8_in_rst", 64'(y8), 64'hFF);

        @(posedge clk);
        #1;
        rst = 1'b0;

        // WIDTH=1 truth table, combinational only
        tbl_ab[0] = 2'b10; tbl_y[0] = 1'b1;
        tbl_ab[1] = 2'b01; tbl_y[1] = 1'b1;
        tbl_ab[2] = 2'b11; tbl_y[2] = 1'b0;
        tbl_ab[3] = 2'b00; tbl_y[3] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            a1 = tbl_ab[i][1];
            b1 = tbl_ab[i][0];
            #1;
            check("y1", 64'(y1), 64'(tbl_y[i]));
            check("all_low1", 64'(al1), 64'(!tbl_y[i]));
            #4;
        end
        check("y_q1_hold", 64'(yq1), 64'd1);
        check("out_valid1_hold", 64'(ov1), 64'd0);

        @(posedge clk);
        #1;

        // Single valid operation, then an idle cycle
        step8(8'hF0, 8'h3C, 1'b1);
        step8(8'hF0, 8'h3C, 1'b0);

        // Back-to-back operations, including the all_low corner
        step8(8'hFF, 8'hFF, 1'b1);
        step8(8'hFF, 8'h00, 1'b1);
        step8(8'hFF, 8'hAA, 1'b1);
        step8(8'h00, 8'h00, 1'b0);

        // Operands toggling with in_valid low
        for (int i = 0; i < 4; i++) begin
            step8(8'($urandom), 8'($urandom), 1'b0);
        end

        // Reset asserted between edges while in_valid is high
        a8 = 8'hFF;
        b8 = 8'h0F;
        v8 = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_regs();
        @(posedge clk);
        #1;
        check_regs();
        rst = 1'b0;
        step8(8'h12, 8'h34, 1'b0);
        step8(8'h12, 8'h34, 1'b0);

        // Saturating count: five valid cycles after reset
        for (int i = 0; i < 5; i++) begin
            step8(8'($urandom), 8'($urandom), 1'b1);
        end

        // Randomized traffic against the reference model
        for (int i = 0; i < 300; i++) begin
            step8(8'($urandom), 8'($urandom),
                  1'($urandom_range(0, 2) != 0));
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
